record_sequence: RTL and testbench
==================================

// Module: record_sequence
// PURPOSE
//  Captures live key presses into sequence_ram so the sequence player can replay them.
//  Write-side counterpart of the player: same 64-step x 10-bit layout, same step period.
//  Sits between the key synchroniser/keyboard front end and the RAM write port
//  (address, data, wren).
// PARAMETERS
//  TICK_CYCLES  6250000  clock cycles per step; must match the player step period; >= 2
//  ADDR_W       6        RAM address width; depth = 2**ADDR_W steps
//  NOTES        10       note gate width; one bit per key
// PORTS
//  clock        in   1        system clock
//  reset        in   1        synchronous, active-high
//  rec_start    in   1        level/pulse; sampled only in IDLE
//  rec_stop     in   1        abort/finish request; wins over rec_start
//  keys         in   NOTES    raw key levels, asynchronous; 1 = pressed
//  ram_address  out  ADDR_W   RAM write address (registered)
//  ram_data     out  NOTES    RAM write data (registered)
//  ram_wren     out  1        RAM write enable, one cycle per write (registered)
//  recording    out  1        high in ARM and RECORD
//  rec_done     out  1        one-cycle pulse when a take completes
//  rec_length   out  ADDR_W+1 steps written in last take, 0..64; held until next rec_start
// BEHAVIOUR
//  - keys pass through a 2-flop synchroniser (keys_s); all decisions use keys_s.
//  - Reset: state=IDLE; ram_address=0, ram_data=0, ram_wren=0, recording=0, rec_done=0,
//    rec_length=0; step counter, accumulator, and address are cleared.
//  - Outputs are registered: a write decided in cycle N appears on the port in cycle N+1.
//  - IDLE: outputs idle (wren=0). rec_start=1 and rec_stop=0 -> CLEAR, addr=0, rec_length=0.
//  - CLEAR: writes 0 to addr on every cycle, addr+1 each cycle; after addr 63 is written
//    -> ARM with addr=0. This takes exactly 64 write cycles. rec_stop -> IDLE (partial
//    clear allowed; rec_length stays 0).
//  - ARM: no writes. Waits until keys_s != 0, then -> RECORD with counter=TICK_CYCLES-1 and
//    acc=keys_s. rec_stop -> IDLE with rec_length=0.
//  - RECORD: each cycle, acc |= keys_s and counter decrements.
//    When counter==0: write ram_data=acc|keys_s at addr; acc<=0; counter reloads to
//    TICK_CYCLES-1; addr+1. Each step is therefore exactly TICK_CYCLES cycles.
//    Step captures any key seen at any time during that step (OR-accumulate).
//    Write of addr 63 -> DONE with rec_length=64; address does not wrap into a second pass.
//  - rec_stop in RECORD: writes acc|keys_s at addr on that cycle (partial final step) ->
//    DONE with rec_length=addr+1. If rec_stop coincides with counter==0, only one write
//    occurs (the tick write); rec_length=addr+1.
//  - DONE: rec_done=1 for exactly one cycle -> IDLE. Steps beyond rec_length keep 0 from CLEAR.
//  - rec_start outside IDLE is ignored. If rec_start and rec_stop are both 1 in IDLE,
//    the block stays in IDLE.
//  - reset in any state aborts the take immediately; writes already performed stay in RAM.
//  - Width rules: counter is 32 bits, unsigned. addr is ADDR_W bits. rec_length is
//    ADDR_W+1 bits, so 64 is representable.
// TESTING (bench uses TICK_CYCLES=4 and a behavioural 64x10 RAM model)
//  1 reset mid-RECORD -> next cycle: state IDLE, wren=0, recording=0, rec_length=0.
//  2 rec_start pulse -> 64 consecutive wren cycles, address 0..63, data 0; then recording=1
//    and no writes while keys=0.
//  3 ARM, keys=10'h001 held 2 cycles, then 10'h200 pulse inside step 0 -> RAM[0]=10'h201,
//    written 4 cycles after the record start; RAM[1]=0 if keys stay idle.
//  4 key held through the full take -> writes at addr 0..63 spaced 4 cycles apart;
//    rec_done pulses once; rec_length=64; no write to addr 0 afterwards.
//  5 rec_stop 2 cycles into step 5 with keys=10'h010 -> RAM[5]=10'h010, rec_length=6,
//    one rec_done pulse, RAM[6..63]=0.
//  6 rec_stop on the same cycle as the step-3 tick -> exactly one write to addr 3,
//    rec_length=4. rec_start+rec_stop together in IDLE -> no CLEAR writes.

Source files
------------

// File: rtl/record_sequence.sv
`default_nettype none
// ============================================================================
// Module      : record_sequence
// Description : Captures live key presses into the 64-step x 10-bit sequence
//               RAM so the sequence player can replay them. It is the
//               write-side counterpart of the player and uses the same step
//               period, so a recorded take plays back at the tempo it was
//               played in.
//
//               A take runs through the following phases:
//                 IDLE   -> wait for rec_start (rec_stop vetoes a start)
//                 CLEAR  -> write zero to every step, one address per cycle
//                 ARM    -> wait for the first key so the take starts on it
//                 RECORD -> OR-accumulate keys over each step, write the
//                           accumulated gate word once per step
//                 DONE   -> one-cycle rec_done pulse, back to IDLE
//
// Ports       :
//   clock        in   1         system clock
//   reset        in   1         synchronous, active-high
//   rec_start    in   1         start a take (sampled only in IDLE)
//   rec_stop     in   1         abort/finish the take; wins over rec_start
//   keys         in   NOTES     raw asynchronous key levels, 1 = pressed
//   ram_address  out  ADDR_W    RAM write address (registered)
//   ram_data     out  NOTES     RAM write data (registered)
//   ram_wren     out  1         RAM write enable, one cycle per write
//   recording    out  1         high while waiting for a key or recording
//   rec_done     out  1         one-cycle pulse when a take completes
//   rec_length   out  ADDR_W+1  steps written in the last take (0..2**ADDR_W)
//
// Revision    : 1.0 - initial release
// ============================================================================
module record_sequence #(
  parameter int TICK_CYCLES = 6250000,  // clock cycles per step, >= 2
  parameter int ADDR_W      = 6,        // RAM address width
  parameter int NOTES       = 10        // one gate bit per key
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic [NOTES-1:0]  keys,
  output logic [ADDR_W-1:0] ram_address,
  output logic [NOTES-1:0]  ram_data,
  output logic              ram_wren,
  output logic              recording,
  output logic              rec_done,
  output logic [ADDR_W:0]   rec_length
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // The step counter counts down from RELOAD to zero, so a step lasts exactly
  // TICK_CYCLES cycles including the cycle on which the step is written.
  localparam logic [31:0]       RELOAD    = 32'(TICK_CYCLES - 1);
  localparam logic [31:0]       CNT_ONE   = 32'd1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ARM    = 3'd2,
    S_RECORD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Key synchroniser
  // --------------------------------------------------------------------------
  // The keys arrive straight from the keyboard front end with no relation to
  // clock. Two flops settle any metastability; only keys_s is used below.
  logic [NOTES-1:0] keys_meta;
  logic [NOTES-1:0] keys_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      keys_meta <= '0;
      keys_s    <= '0;
    end else begin
      keys_meta <= keys;
      keys_s    <= keys_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  state_t            state;
  logic [31:0]       counter;   // cycles left in the current step
  logic [NOTES-1:0]  acc;       // keys seen so far in the current step
  logic [ADDR_W-1:0] addr;      // next RAM location to write

  // The word written for a step includes the keys present on the write cycle
  // itself, so a press landing on the very last cycle of a step is not lost.
  logic [NOTES-1:0]  step_bits;
  // Length of the take if it ends with the write at addr. One bit wider than
  // addr so that a full take of 2**ADDR_W steps is representable.
  logic [ADDR_W:0]   next_length;
  // A step is written either on its natural tick or early on a stop request.
  logic              step_write;

  assign step_bits   = acc | keys_s;
  assign next_length = {1'b0, addr} + LEN_ONE;
  assign step_write  = (counter == '0) || rec_stop;

  // --------------------------------------------------------------------------
  // Control FSM and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      counter     <= '0;
      acc         <= '0;
      addr        <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      recording   <= 1'b0;
      rec_done    <= 1'b0;
      rec_length  <= '0;
    end else begin
      // Write enable and completion flag are single-cycle strobes; every
      // branch that wants them asserts them explicitly.
      ram_wren <= 1'b0;
      rec_done <= 1'b0;

      case (state)
        // ------------------------------------------------------------------
        S_IDLE: begin
          recording <= 1'b0;
          // rec_stop vetoes a start so a held stop button keeps us parked.
          if (rec_start && !rec_stop) begin
            state      <= S_CLEAR;
            addr       <= '0;
            rec_length <= '0;
          end
        end

        // ------------------------------------------------------------------
        // Zero every step so that anything past the end of a short take
        // plays back as silence.
        S_CLEAR: begin
          if (rec_stop) begin
            // Aborting leaves a partially cleared RAM; rec_length is 0.
            state     <= S_IDLE;
            recording <= 1'b0;
            addr      <= '0;
          end else begin
            ram_wren    <= 1'b1;
            ram_address <= addr;
            ram_data    <= '0;
            if (addr == LAST_ADDR) begin
              addr      <= '0;
              state     <= S_ARM;
              recording <= 1'b1;
            end else begin
              addr <= addr + ADDR_ONE;
            end
          end
        end

        // ------------------------------------------------------------------
        // Hold off until the player presses something, so the take does not
        // start with a run of empty steps. The first key's cycle joins step 0.
        S_ARM: begin
          if (rec_stop) begin
            state      <= S_IDLE;
            recording  <= 1'b0;
            rec_length <= '0;
          end else if (keys_s != '0) begin
            state   <= S_RECORD;
            counter <= RELOAD;
            acc     <= keys_s;
          end
        end

        // ------------------------------------------------------------------
        S_RECORD: begin
          if (step_write) begin
            // A stop that coincides with the tick shares the tick's write,
            // so a step is never written twice.
            ram_wren    <= 1'b1;
            ram_address <= addr;
            ram_data    <= step_bits;
            acc         <= '0;
            counter     <= RELOAD;
            if (rec_stop || (addr == LAST_ADDR)) begin
              // The take ends here; the address never wraps to a second pass.
              state      <= S_DONE;
              recording  <= 1'b0;
              rec_done   <= 1'b1;
              rec_length <= next_length;
            end else begin
              addr <= addr + ADDR_ONE;
            end
          end else begin
            acc     <= step_bits;
            counter <= counter - CNT_ONE;
          end
        end

        // ------------------------------------------------------------------
        // rec_done was raised on entry; it drops again as we return to IDLE.
        S_DONE: begin
          state     <= S_IDLE;
          recording <= 1'b0;
        end

        // ------------------------------------------------------------------
        default: begin
          state     <= S_IDLE;
          recording <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_record_sequence.sv
`default_nettype none
// ============================================================================
// Module      : tb_record_sequence
// Description : Self-checking bench for record_sequence. A behavioural model
//               of the recorder (phase, step position, accumulated keys and a
//               64-entry RAM image) predicts every output each cycle; directed
//               takes pin the model against hand-computed values, then a
//               randomized run exercises starts, stops, keys and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_record_sequence;

  localparam int TICK  = 4;
  localparam int AW    = 6;
  localparam int NW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          rec_start;
  logic          rec_stop;
  logic [NW-1:0] keys;
  logic [AW-1:0] ram_address;
  logic [NW-1:0] ram_data;
  logic          ram_wren;
  logic          recording;
  logic          rec_done;
  logic [AW:0]   rec_length;

  record_sequence #(
    .TICK_CYCLES (TICK),
    .ADDR_W      (AW),
    .NOTES       (NW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rec_start   (rec_start),
    .rec_stop    (rec_stop),
    .keys        (keys),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .recording   (recording),
    .rec_done    (rec_done),
    .rec_length  (rec_length)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: phases 0 idle, 1 clearing, 2 waiting for first key,
  // 3 capturing, 4 finishing. A step is TICK cycles long, counted by its age.
  // --------------------------------------------------------------------------
  int          m_mode = 0;
  int          m_ptr  = 0;
  int          m_age  = 0;
  logic [NW-1:0] m_seen = '0;
  logic [NW-1:0] ks1 = '0, ks2 = '0;
  logic [NW-1:0] m_ram [DEPTH];
  logic        m_wren = 0, m_rec = 0, m_done = 0;
  int          m_addr = 0;
  logic [NW-1:0] m_data = '0;
  int          m_len  = 0;

  initial for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;

  always @(posedge clock) begin
    logic [NW-1:0] ks;
    ks = ks2;
    if (reset) begin
      m_mode = 0; m_ptr = 0; m_age = 0; m_seen = '0;
      m_wren = 0; m_addr = 0; m_data = '0; m_rec = 0; m_done = 0; m_len = 0;
      ks1 = '0; ks2 = '0;
    end else begin
      m_wren = 0;
      m_done = 0;
      case (m_mode)
        0: if (rec_start && !rec_stop) begin m_mode = 1; m_ptr = 0; m_len = 0; end
        1: if (rec_stop) m_mode = 0;
           else begin
             m_wren = 1; m_addr = m_ptr; m_data = '0; m_ram[m_ptr] = '0;
             if (m_ptr == DEPTH - 1) begin m_mode = 2; m_ptr = 0; end
             else m_ptr++;
           end
        2: if (rec_stop) begin m_mode = 0; m_len = 0; end
           else if (ks != '0) begin m_mode = 3; m_age = 0; m_seen = ks; end
        3: if (m_age == TICK - 1 || rec_stop) begin
             m_wren = 1; m_addr = m_ptr; m_data = m_seen | ks; m_ram[m_ptr] = m_seen | ks;
             if (m_ptr == DEPTH - 1 || rec_stop) begin
               m_mode = 4; m_len = m_ptr + 1; m_done = 1;
             end else begin
               m_ptr++; m_age = 0; m_seen = '0;
             end
           end else begin
             m_seen = m_seen | ks; m_age++;
           end
        default: m_mode = 0;
      endcase
      m_rec = (m_mode == 2 || m_mode == 3);
      ks2 = ks1;
      ks1 = keys;
    end
  end

  // Cycle-by-cycle comparison against the model.
  logic cmp_en = 0;
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("wren", ram_wren, m_wren);
      chk("recording", recording, m_rec);
      chk("rec_done", rec_done, m_done);
      chk("rec_length", rec_length, m_len);
      if (m_wren) begin
        chk("address", ram_address, m_addr);
        chk("data", ram_data, m_data);
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM built from the DUT's write port, plus write statistics.
  // --------------------------------------------------------------------------
  logic [NW-1:0] ram [DEPTH];
  int wr_count [DEPTH];
  int cnt_wren = 0, cnt_done = 0, rec_writes = 0, gap_bad = 0, last_nz = -1, cyc = 0;

  initial for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; wr_count[i] = 0; end

  always begin
    @(posedge clock);
    #2;
    cyc++;
    if (ram_wren) begin
      ram[ram_address] = ram_data;
      wr_count[ram_address]++;
      cnt_wren++;
      if (ram_data != '0) begin
        if (last_nz >= 0 && cyc - last_nz != TICK) gap_bad++;
        last_nz = cyc;
        rec_writes++;
      end
    end
    if (rec_done) cnt_done++;
  end

  task automatic clear_counters();
    for (int i = 0; i < DEPTH; i++) wr_count[i] = 0;
    cnt_wren = 0; cnt_done = 0; rec_writes = 0; gap_bad = 0; last_nz = -1;
  endtask

  task automatic pulse_start();
    @(negedge clock) rec_start = 1;
    @(negedge clock) rec_start = 0;
  endtask

  task automatic pulse_stop();
    rec_stop = 1;
    @(negedge clock) rec_stop = 0;
  endtask

  // Wait until the model emits the write of step a while capturing.
  task automatic wait_rec_write(input int a);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (m_wren && m_mode == 3 && m_addr == a) return;
    end
    checks++; errors++;
    $display("FAIL wait_rec_write: step %0d write not seen within 2000 cycles", a);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      if (cnt_done >= 1) return;
    end
    checks++; errors++;
    $display("FAIL wait_done: rec_done not seen within 1500 cycles");
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int bad;
    reset = 1; rec_start = 0; rec_stop = 0; keys = '0;
    repeat (3) @(negedge clock);
    chk("reset_wren", ram_wren, 0);
    chk("reset_address", ram_address, 0);
    chk("reset_data", ram_data, 0);
    chk("reset_recording", recording, 0);
    chk("reset_rec_done", rec_done, 0);
    chk("reset_rec_length", rec_length, 0);
    cmp_en = 1;
    reset = 0;
    repeat (2) @(negedge clock);

    // Clear pass, then a two-key chord accumulated into step 0.
    clear_counters();
    pulse_start();
    repeat (68) @(negedge clock);
    chk("clear_write_count", cnt_wren, 64);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (wr_count[i] != 1) bad++;
    chk("clear_each_addr_once", bad, 0);
    chk("armed_recording", recording, 1);
    chk("armed_no_write", ram_wren, 0);
    keys = 10'h001;
    repeat (2) @(negedge clock);
    keys = 10'h200;
    @(negedge clock) keys = '0;
    wait_rec_write(2);
    pulse_stop();
    repeat (5) @(negedge clock);
    chk("chord_ram0", ram[0], 10'h201);
    chk("chord_ram1", ram[1], 10'h000);
    chk("chord_done_pulses", cnt_done, 1);

    // Full take with a key held throughout.
    clear_counters();
    keys = 10'h004;
    pulse_start();
    wait_done();
    repeat (20) @(negedge clock);
    keys = '0;
    chk("full_rec_length", rec_length, 64);
    chk("full_done_pulses", cnt_done, 1);
    chk("full_record_writes", rec_writes, 64);
    chk("full_step_spacing_bad", gap_bad, 0);
    chk("full_addr0_writes", wr_count[0], 2);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] != 10'h004) bad++;
    chk("full_ram_content_bad", bad, 0);

    // Stop two cycles into step 5.
    clear_counters();
    keys = 10'h010;
    pulse_start();
    wait_rec_write(4);
    @(negedge clock);
    pulse_stop();
    repeat (6) @(negedge clock);
    keys = '0;
    chk("stop5_ram5", ram[5], 10'h010);
    chk("stop5_rec_length", rec_length, 6);
    chk("stop5_done_pulses", cnt_done, 1);
    bad = 0;
    for (int i = 6; i < DEPTH; i++) if (ram[i] != '0) bad++;
    chk("stop5_tail_zero_bad", bad, 0);

    // Stop on the step-3 tick: a single write to step 3.
    clear_counters();
    keys = 10'h020;
    pulse_start();
    wait_rec_write(2);
    repeat (3) @(negedge clock);
    pulse_stop();
    repeat (6) @(negedge clock);
    keys = '0;
    chk("tickstop_addr3_writes", wr_count[3], 2);
    chk("tickstop_addr4_writes", wr_count[4], 1);
    chk("tickstop_rec_length", rec_length, 4);
    chk("tickstop_done_pulses", cnt_done, 1);

    // Start and stop together in idle: nothing happens.
    clear_counters();
    @(negedge clock) begin rec_start = 1; rec_stop = 1; end
    @(negedge clock) begin rec_start = 0; rec_stop = 0; end
    repeat (10) @(negedge clock);
    chk("startstop_no_writes", cnt_wren, 0);
    chk("startstop_idle", recording, 0);

    // Reset in the middle of a take.
    keys = 10'h001;
    pulse_start();
    wait_rec_write(1);
    reset = 1;
    @(negedge clock);
    chk("midreset_wren", ram_wren, 0);
    chk("midreset_recording", recording, 0);
    chk("midreset_rec_length", rec_length, 0);
    reset = 0;
    keys = '0;

    // Randomized run.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      keys      = ($urandom_range(0, 5) == 0) ? NW'($urandom) : '0;
      rec_start = ($urandom_range(0, 39) == 0);
      rec_stop  = ($urandom_range(0, 199) == 0);
      reset     = ($urandom_range(0, 2499) == 0);
    end
    @(negedge clock) begin keys = '0; rec_start = 0; rec_stop = 0; reset = 0; end
    repeat (3) @(negedge clock);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== m_ram[i]) bad++;
    chk("final_ram_image_bad", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
